// File: rtl/serial_add_ctrl.sv
// Multi-operand adder: sums 1..7 operands through a single bit-serial full adder, LSB first.
// Result after 2+(n-1)*(WIDTH+1) cycles; operand and result sides use valid/ready handshakes.

module full_adder (
    input  logic x,
    input  logic y,
    input  logic c_in1,
    output logic sum1,
    output logic cout1
);
    assign sum1  = x ^ y ^ c_in1;
    assign cout1 = (x & y) | (c_in1 & (x ^ y));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       num_ops,
    input  logic             op_valid,
    input  logic [WIDTH-1:0] op_data,
    output logic             op_ready,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_OP = 2'd1,
        ADD     = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] opreg_q, opreg_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [2:0]       op_cnt_q, op_cnt_d;
    logic [2:0]       num_ops_q, num_ops_d;
    logic             op_ready_q, op_ready_d;
    logic             busy_q, busy_d;
    logic             result_valid_q, result_valid_d;

    logic fa_sum;
    logic fa_cout;

    full_adder u_fa (
        .x     (acc_q[0]),
        .y     (opreg_q[0]),
        .c_in1 (carry_q),
        .sum1  (fa_sum),
        .cout1 (fa_cout)
    );

    always_comb begin
        state_d        = state_q;
        acc_d          = acc_q;
        opreg_d        = opreg_q;
        carry_d        = carry_q;
        bit_cnt_d      = bit_cnt_q;
        op_cnt_d       = op_cnt_q;
        num_ops_d      = num_ops_q;
        op_ready_d     = op_ready_q;
        busy_d         = busy_q;
        result_valid_d = result_valid_q;

        case (state_q)
            IDLE: begin
                if (start && (num_ops != 3'd0)) begin
                    num_ops_d  = num_ops;
                    op_cnt_d   = 3'd0;
                    state_d    = WAIT_OP;
                    op_ready_d = 1'b1;
                    busy_d     = 1'b1;
                end
            end

            WAIT_OP: begin
                if (op_valid && op_ready_q) begin
                    op_cnt_d = op_cnt_q + 3'd1;
                    if (op_cnt_q == 3'd0) begin
                        // First operand seeds the accumulator without an add pass.
                        acc_d = op_data;
                        if (num_ops_q == 3'd1) begin
                            state_d    = DONE;
                            op_ready_d = 1'b0;
                        end
                    end else begin
                        opreg_d    = op_data;
                        carry_d    = 1'b0;
                        bit_cnt_d  = '0;
                        state_d    = ADD;
                        op_ready_d = 1'b0;
                    end
                end
            end

            ADD: begin
                acc_d            = acc_q >> 1;
                acc_d[WIDTH-1]   = fa_sum;
                opreg_d          = opreg_q >> 1;
                carry_d          = fa_cout;
                bit_cnt_d        = bit_cnt_q + 1'b1;
                if (bit_cnt_q == LAST_BIT) begin
                    if (op_cnt_q == num_ops_q) begin
                        state_d = DONE;
                    end else begin
                        state_d    = WAIT_OP;
                        op_ready_d = 1'b1;
                    end
                end
            end

            DONE: begin
                // result_valid follows DONE entry by one cycle; handshake needs it high.
                if (result_valid_q && result_ready) begin
                    state_d        = IDLE;
                    result_valid_d = 1'b0;
                    busy_d         = 1'b0;
                end else begin
                    result_valid_d = 1'b1;
                end
            end

            default: begin
                state_d        = IDLE;
                op_ready_d     = 1'b0;
                busy_d         = 1'b0;
                result_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            acc_q          <= '0;
            opreg_q        <= '0;
            carry_q        <= 1'b0;
            bit_cnt_q      <= '0;
            op_cnt_q       <= 3'd0;
            num_ops_q      <= 3'd0;
            op_ready_q     <= 1'b0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            acc_q          <= acc_d;
            opreg_q        <= opreg_d;
            carry_q        <= carry_d;
            bit_cnt_q      <= bit_cnt_d;
            op_cnt_q       <= op_cnt_d;
            num_ops_q      <= num_ops_d;
            op_ready_q     <= op_ready_d;
            busy_q         <= busy_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign op_ready     = op_ready_q;
    assign result_valid = result_valid_q;
    assign result       = acc_q;
    assign busy         = busy_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: scoreboard of model sums, latency and handshake checks.
module tb_serial_add_ctrl;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   num_ops;
    logic         op_valid;
    logic [W-1:0] op_data;
    logic         op_ready;
    logic         result_valid;
    logic         result_ready;
    logic [W-1:0] result;
    logic         busy;

    int           cyc = 0;
    int           vectors = 0;
    int           miscompares = 0;
    int           t_start = 0;
    logic [W-1:0] exp_q [$];
    logic [W-1:0] opv [7];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .num_ops      (num_ops),
        .op_valid     (op_valid),
        .op_data      (op_data),
        .op_ready     (op_ready),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result       (result),
        .busy         (busy)
    );

    task automatic do_start(input logic [2:0] n);
        start   = 1'b1;
        num_ops = n;
        @(negedge clk);
        start   = 1'b0;
        t_start = cyc;
    endtask

    task automatic send_op(input logic [W-1:0] d, input int gap, output bit ok);
        int k = 0;
        repeat (gap) @(negedge clk);
        op_valid = 1'b1;
        op_data  = d;
        while (!op_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        ok = op_ready;
        if (ok) @(negedge clk);
        op_valid = 1'b0;
        op_data  = $urandom;
    endtask

    task automatic drive_sum(input int n, input int gap, output bit ok);
        logic [W-1:0] s = '0;
        bit o;
        ok = 1'b1;
        do_start(3'(n));
        for (int i = 0; i < n; i++) begin
            s = s + opv[i];
            send_op(opv[i], (i == 0) ? 0 : gap, o);
            ok = ok & o;
        end
        exp_q.push_back(s);
    endtask

    task automatic wait_result(output bit ok, output int lat);
        int k = 0;
        while (!result_valid && k < 500) begin
            @(negedge clk);
            k++;
        end
        ok  = result_valid;
        lat = cyc - t_start;
    endtask

    task automatic ack;
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; num_ops = 3'd0; op_valid = 1'b0;
        op_data = '0; result_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++; if (op_ready !== 1'b0) begin miscompares++; $display("FAIL reset_op_ready: got %b want 0", op_ready); end
        vectors++; if (result_valid !== 1'b0) begin miscompares++; $display("FAIL reset_result_valid: got %b want 0", result_valid); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (result !== '0) begin miscompares++; $display("FAIL reset_result: got %h want 0", result); end
    endtask

    task automatic test_wrap;
        bit ok; int lat; logic [W-1:0] e;
        opv[0] = 32'hFFFF_FFFF; opv[1] = 32'h0000_0001;
        drive_sum(2, 0, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL wrap_accept: got timeout want accept"); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL wrap_busy: got %b want 1", busy); end
        wait_result(ok, lat);
        e = exp_q.pop_front();
        vectors++; if (!ok) begin miscompares++; $display("FAIL wrap_valid: got timeout want result_valid"); end
        vectors++; if (result !== e) begin miscompares++; $display("FAIL wrap_result: got %h want %h", result, e); end
        vectors++; if (lat !== 35) begin miscompares++; $display("FAIL wrap_latency: got %0d want 35", lat); end
        ack();
        vectors++; if (busy !== 1'b0 || result_valid !== 1'b0) begin miscompares++; $display("FAIL wrap_release: got busy=%b valid=%b want 0 0", busy, result_valid); end
    endtask

    task automatic test_five;
        bit ok; int lat; logic [W-1:0] e;
        opv[0] = 32'h6A09_E667; opv[1] = 32'hBB67_AE85; opv[2] = 32'h3C6E_F372;
        opv[3] = 32'hA54F_F53A; opv[4] = 32'h510E_527F;
        drive_sum(5, 0, ok);
        wait_result(ok, lat);
        e = exp_q.pop_front();
        vectors++; if (!ok) begin miscompares++; $display("FAIL five_valid: got timeout want result_valid"); end
        vectors++; if (result !== e) begin miscompares++; $display("FAIL five_result: got %h want %h", result, e); end
        vectors++; if (lat !== 2 + 4 * (W + 1)) begin miscompares++; $display("FAIL five_latency: got %0d want %0d", lat, 2 + 4 * (W + 1)); end
        ack();
    endtask

    task automatic test_one;
        bit ok; int lat; logic [W-1:0] e;
        opv[0] = 32'h1234_5678;
        drive_sum(1, 0, ok);
        wait_result(ok, lat);
        e = exp_q.pop_front();
        vectors++; if (result !== e) begin miscompares++; $display("FAIL one_result: got %h want %h", result, e); end
        vectors++; if (lat !== 2) begin miscompares++; $display("FAIL one_latency: got %0d want 2", lat); end
        ack();
    endtask

    task automatic test_gaps;
        bit ok; int lat; logic [W-1:0] e;
        opv[0] = 32'h0F0F_1234; opv[1] = 32'hF0F0_FFFF; opv[2] = 32'h8000_0001;
        drive_sum(3, 3, ok);
        wait_result(ok, lat);
        e = exp_q.pop_front();
        vectors++; if (!ok) begin miscompares++; $display("FAIL gaps_valid: got timeout want result_valid"); end
        for (int i = 0; i < 10; i++) begin
            vectors++; if (result !== e) begin miscompares++; $display("FAIL gaps_hold_result[%0d]: got %h want %h", i, result, e); end
            vectors++; if (busy !== 1'b1 || result_valid !== 1'b1) begin miscompares++; $display("FAIL gaps_hold_flags[%0d]: got busy=%b valid=%b want 1 1", i, busy, result_valid); end
            @(negedge clk);
        end
        ack();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL gaps_release: got busy=%b want 0", busy); end
    endtask

    task automatic test_rst_mid;
        bit ok; int lat; logic [W-1:0] e;
        do_start(3'd2);
        send_op(32'hDEAD_BEEF, 0, ok);
        send_op(32'h0000_1234, 0, ok);
        repeat (17) @(negedge clk);
        rst = 1'b1;
        start = 1'b1; num_ops = 3'd2; result_ready = 1'b1; op_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0; result_ready = 1'b0; op_valid = 1'b0;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        vectors++; if (result !== '0) begin miscompares++; $display("FAIL rstmid_result: got %h want 0", result); end
        vectors++; if (op_ready !== 1'b0) begin miscompares++; $display("FAIL rstmid_op_ready: got %b want 0", op_ready); end
        opv[0] = 32'h0000_0003; opv[1] = 32'h0000_0004;
        drive_sum(2, 0, ok);
        wait_result(ok, lat);
        e = exp_q.pop_front();
        vectors++; if (result !== e) begin miscompares++; $display("FAIL rstmid_fresh: got %h want %h", result, e); end
        ack();
    endtask

    task automatic test_ignore;
        bit ok; int lat; logic [W-1:0] e;
        do_start(3'd0);
        repeat (2) @(negedge clk);
        vectors++; if (busy !== 1'b0 || op_ready !== 1'b0) begin miscompares++; $display("FAIL ignore_zero_ops: got busy=%b op_ready=%b want 0 0", busy, op_ready); end
        opv[0] = 32'h89AB_CDEF; opv[1] = 32'h7654_3211;
        drive_sum(2, 0, ok);
        repeat (5) @(negedge clk);
        start = 1'b1; num_ops = 3'd5; op_valid = 1'b1; op_data = 32'h5555_AAAA;
        @(negedge clk);
        start = 1'b0; op_valid = 1'b0;
        wait_result(ok, lat);
        e = exp_q.pop_front();
        vectors++; if (result !== e) begin miscompares++; $display("FAIL ignore_result: got %h want %h", result, e); end
        vectors++; if (lat !== 35) begin miscompares++; $display("FAIL ignore_latency: got %0d want 35", lat); end
        ack();
        @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL ignore_idle: got busy=%b want 0", busy); end
    endtask

    task automatic test_back_to_back;
        bit ok; int lat; int n; logic [W-1:0] e;
        for (int r = 0; r < 5; r++) begin
            n = $urandom_range(1, 7);
            for (int i = 0; i < 7; i++) opv[i] = $urandom;
            drive_sum(n, 0, ok);
            wait_result(ok, lat);
            e = exp_q.pop_front();
            vectors++; if (result !== e) begin miscompares++; $display("FAIL b2b_result[%0d] n=%0d: got %h want %h", r, n, result, e); end
            vectors++; if (lat !== 2 + (n - 1) * (W + 1)) begin miscompares++; $display("FAIL b2b_latency[%0d] n=%0d: got %0d want %0d", r, n, lat, 2 + (n - 1) * (W + 1)); end
            ack();
        end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_five();
        test_one();
        test_gaps();
        test_rst_mid();
        test_ignore();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion want summary before timeout");
        $fatal(1, "watchdog expired");
    end
endmodule
